// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus around mem_port_arbiter.
// master = requesters plus memory block, slave = the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              ctrl_mem_read;
  logic              ctrl_mem_write;
  logic              busy;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  mem_addr, mem_write_data, ctrl_mem_read, ctrl_mem_write, busy,
    output mem_read_data
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output mem_addr, mem_write_data, ctrl_mem_read, ctrl_mem_write, busy,
    input  mem_read_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and load/store (port 1); each grant runs a fixed IDLE -> ACCESS -> RESP sequence.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              win_c;
  logic              any_req_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  // Winner selection: on a tie the port not granted last time wins.
  always_comb begin
    any_req_c   = bus.m0_req | bus.m1_req;
    win_c       = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;
    sel_we_c    = win_c ? bus.m1_we    : bus.m0_we;
    sel_addr_c  = win_c ? bus.m1_addr  : bus.m0_addr;
    sel_wdata_c = win_c ? bus.m1_wdata : bus.m0_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      last_grant         <= 1'b1;
      port_q             <= 1'b0;
      we_q               <= 1'b0;
      addr_q             <= '0;
      wdata_q            <= '0;
      rdata_q            <= '0;
      bus.m0_ack         <= 1'b0;
      bus.m1_ack         <= 1'b0;
      bus.m0_rdata       <= '0;
      bus.m1_rdata       <= '0;
      bus.mem_addr       <= '0;
      bus.mem_write_data <= '0;
      bus.ctrl_mem_read  <= 1'b0;
      bus.ctrl_mem_write <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      bus.m0_ack   <= 1'b0;
      bus.m1_ack   <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m1_rdata <= '0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            state              <= ACCESS;
            cnt                <= CNT_W'(WAIT_CYCLES - 1);
            last_grant         <= win_c;
            port_q             <= win_c;
            we_q               <= sel_we_c;
            addr_q             <= sel_addr_c;
            wdata_q            <= sel_wdata_c;
            bus.mem_addr       <= sel_addr_c;
            bus.mem_write_data <= sel_wdata_c;
            bus.ctrl_mem_read  <= ~sel_we_c;
            bus.ctrl_mem_write <= sel_we_c;
            bus.busy           <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state              <= RESP;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
            bus.ctrl_mem_read  <= 1'b0;
            bus.ctrl_mem_write <= 1'b0;
            if (!we_q) begin
              rdata_q <= bus.mem_read_data;
            end
            // Response data is what rdata_q holds once this edge has landed.
            if (port_q) begin
              bus.m1_ack   <= 1'b1;
              bus.m1_rdata <= we_q ? rdata_q : bus.mem_read_data;
            end else begin
              bus.m0_ack   <= 1'b1;
              bus.m0_rdata <= we_q ? rdata_q : bus.mem_read_data;
            end
          end else begin
            cnt                <= cnt - CNT_W'(1);
            bus.mem_addr       <= addr_q;
            bus.mem_write_data <= wdata_q;
          end
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table, randomized traffic against a
// transaction-level reference model, and a WAIT_CYCLES=3 directed sequence.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned WA = 1;
  localparam int unsigned WB = 3;

  typedef logic [132:0] obs_t;

  typedef struct {
    bit          rst;
    bit          r0;
    bit          we0;
    logic [31:0] a0;
    logic [31:0] d0;
    bit          r1;
    bit          we1;
    logic [31:0] a1;
    logic [31:0] d1;
    bit          e_rd;
    bit          e_wr;
    bit          e_busy;
    bit          e_ack0;
    bit          e_ack1;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WA)) u_dut_a (
    .clk(clk), .rst(rst), .bus(a)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WB)) u_dut_b (
    .clk(clk), .rst(rst), .bus(b)
  );

  function automatic logic [31:0] init_word(input logic [5:0] i);
    return (i == 6'd5) ? 32'd1337 : (32'h0000_1000 + 32'(i));
  endfunction

  // Word-addressed memories with combinational read; unwritten words hold init_word.
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [63:0] wr_a = '0;
  logic [63:0] wr_b = '0;

  assign a.mem_read_data = wr_a[a.mem_addr[7:2]] ? mem_a[a.mem_addr[7:2]] : init_word(a.mem_addr[7:2]);
  assign b.mem_read_data = wr_b[b.mem_addr[7:2]] ? mem_b[b.mem_addr[7:2]] : init_word(b.mem_addr[7:2]);

  always @(posedge clk) begin
    if (a.ctrl_mem_write) begin
      mem_a[a.mem_addr[7:2]] <= a.mem_write_data;
      wr_a[a.mem_addr[7:2]]  <= 1'b1;
    end
    if (b.ctrl_mem_write) begin
      mem_b[b.mem_addr[7:2]] <= b.mem_write_data;
      wr_b[b.mem_addr[7:2]]  <= 1'b1;
    end
  end

  function automatic obs_t mk_obs(input bit rd, input bit wr, input bit bsy, input bit k0, input bit k1,
                                  input logic [31:0] ad, input logic [31:0] wd,
                                  input logic [31:0] q0, input logic [31:0] q1);
    return {rd, wr, bsy, k0, k1, ad, wd, q0, q1};
  endfunction

  function automatic obs_t got_a();
    return mk_obs(a.ctrl_mem_read, a.ctrl_mem_write, a.busy, a.m0_ack, a.m1_ack,
                  a.mem_addr, a.mem_write_data, a.m0_rdata, a.m1_rdata);
  endfunction

  function automatic obs_t got_b();
    return mk_obs(b.ctrl_mem_read, b.ctrl_mem_write, b.busy, b.m0_ack, b.m1_ack,
                  b.mem_addr, b.mem_write_data, b.m0_rdata, b.m1_rdata);
  endfunction

  task automatic chk(input string name, input int idx, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got {rd,wr,busy,ack0,ack1,addr,wdata,rdata0,rdata1}=%h required %h",
               name, idx, got, exp);
    end
  endtask

  // Reference model for instance a: one transaction at a time, tracked by cycles since grant.
  bit          m_valid = 1'b0;
  bit          m_act   = 1'b0;
  bit          m_last  = 1'b1;
  bit          m_port;
  bit          m_we;
  int          m_ph;
  int          m_cyc   = 0;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdq   = '0;
  logic [31:0] mm [64];
  logic [63:0] mm_w    = '0;

  function automatic logic [31:0] model_read(input logic [31:0] ad);
    return mm_w[ad[7:2]] ? mm[ad[7:2]] : init_word(ad[7:2]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_act   = 1'b0;
      m_last  = 1'b1;
      m_rdq   = '0;
    end else if (m_act) begin
      m_ph++;
      if (m_ph == int'(WA) + 1 && !m_we) m_rdq = model_read(m_addr);
      if (m_ph == int'(WA) + 2) m_act = 1'b0;
    end else if (a.m0_req || a.m1_req) begin
      m_port  = (a.m0_req && a.m1_req) ? !m_last : a.m1_req;
      m_last  = m_port;
      m_act   = 1'b1;
      m_ph    = 1;
      m_we    = m_port ? a.m1_we    : a.m0_we;
      m_addr  = m_port ? a.m1_addr  : a.m0_addr;
      m_wdata = m_port ? a.m1_wdata : a.m0_wdata;
      if (m_we) begin
        mm[m_addr[7:2]]   = m_wdata;
        mm_w[m_addr[7:2]] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit acc;
    bit rsp;
    if (m_valid) begin
      acc = m_act && (m_ph <= int'(WA));
      rsp = m_act && (m_ph == int'(WA) + 1);
      chk("model", m_cyc, got_a(),
          mk_obs(acc && !m_we, acc && m_we, acc || rsp, rsp && !m_port, rsp && m_port,
                 acc ? m_addr : 32'd0, acc ? m_wdata : 32'd0,
                 (rsp && !m_port) ? m_rdq : 32'd0, (rsp && m_port) ? m_rdq : 32'd0));
      m_cyc++;
    end
  end

  function automatic vec_t v(input bit rs, input bit r0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                             input bit r1, input bit we1, input logic [31:0] a1, input logic [31:0] d1,
                             input bit rd, input bit wr, input bit bsy, input bit k0, input bit k1,
                             input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] q0, input logic [31:0] q1);
    vec_t t;
    t = '{rs, r0, we0, a0, d0, r1, we1, a1, d1, rd, wr, bsy, k0, k1, ad, wd, q0, q1};
    return t;
  endfunction

  vec_t vq[$];
  bit   pend0;
  bit   pend1;
  obs_t exp_b [6];
  int   rd_cnt;
  int   ack_cnt;

  initial begin
    rst = 1'b1;
    {a.m0_req, a.m0_we, a.m1_req, a.m1_we} = '0;
    {a.m0_addr, a.m0_wdata, a.m1_addr, a.m1_wdata} = '0;
    {b.m0_req, b.m0_we, b.m1_req, b.m1_we} = '0;
    {b.m0_addr, b.m0_wdata, b.m1_addr, b.m1_wdata} = '0;

    //        rst r0 we0 a0 d0  r1 we1 a1 d1   rd wr bsy k0 k1 addr wdata rd0  rd1
    vq.push_back(v(1, 0,0, 0,0,  0,0,0,0,      0,0,0,0,0, 0, 0,  0,    0));
    vq.push_back(v(0, 1,0,20,0,  0,0,0,0,      1,0,1,0,0, 20,0,  0,    0));
    vq.push_back(v(0, 1,0,20,0,  0,0,0,0,      0,0,1,1,0, 0, 0,  1337, 0));
    vq.push_back(v(0, 0,0, 0,0,  0,0,0,0,      0,0,0,0,0, 0, 0,  0,    0));
    vq.push_back(v(0, 0,0, 0,0,  1,1,8,15,     0,1,1,0,0, 8, 15, 0,    0));
    vq.push_back(v(0, 0,0, 0,0,  1,1,8,15,     0,0,1,0,1, 0, 0,  0,    1337));
    vq.push_back(v(0, 0,0, 0,0,  0,0,0,0,      0,0,0,0,0, 0, 0,  0,    0));
    vq.push_back(v(0, 0,0, 0,0,  1,0,8,0,      1,0,1,0,0, 8, 0,  0,    0));
    vq.push_back(v(0, 0,0, 0,0,  1,0,8,0,      0,0,1,0,1, 0, 0,  0,    15));
    vq.push_back(v(0, 0,0, 0,0,  0,0,0,0,      0,0,0,0,0, 0, 0,  0,    0));
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) vq.push_back(v(0, 1,0,20,0, 1,0,8,0, 1,0,1,0,0, 20,0, 0,    0));
      else            vq.push_back(v(0, 1,0,20,0, 1,0,8,0, 1,0,1,0,0, 8, 0, 0,    0));
      if (i % 2 == 0) vq.push_back(v(0, 1,0,20,0, 1,0,8,0, 0,0,1,1,0, 0, 0, 1337, 0));
      else            vq.push_back(v(0, 1,0,20,0, 1,0,8,0, 0,0,1,0,1, 0, 0, 0,    15));
      if (i < 3)      vq.push_back(v(0, 1,0,20,0, 1,0,8,0, 0,0,0,0,0, 0, 0, 0,    0));
      else            vq.push_back(v(0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0, 0, 0, 0,    0));
    end
    vq.push_back(v(0, 1,0,20,0,  0,0,0,0,      1,0,1,0,0, 20,0,  0,    0));
    vq.push_back(v(0, 0,0,40,0,  0,0,0,0,      0,0,1,1,0, 0, 0,  1337, 0));
    vq.push_back(v(0, 0,0, 0,0,  0,0,0,0,      0,0,0,0,0, 0, 0,  0,    0));
    vq.push_back(v(0, 0,0, 0,0,  1,0,8,0,      1,0,1,0,0, 8, 0,  0,    0));
    vq.push_back(v(1, 0,0, 0,0,  1,0,8,0,      0,0,0,0,0, 0, 0,  0,    0));
    vq.push_back(v(0, 1,0,20,0,  1,0,8,0,      1,0,1,0,0, 20,0,  0,    0));
    vq.push_back(v(0, 1,0,20,0,  1,0,8,0,      0,0,1,1,0, 0, 0,  1337, 0));
    vq.push_back(v(0, 0,0, 0,0,  0,0,0,0,      0,0,0,0,0, 0, 0,  0,    0));

    foreach (vq[i]) begin
      rst        = vq[i].rst;
      a.m0_req   = vq[i].r0;
      a.m0_we    = vq[i].we0;
      a.m0_addr  = vq[i].a0;
      a.m0_wdata = vq[i].d0;
      a.m1_req   = vq[i].r1;
      a.m1_we    = vq[i].we1;
      a.m1_addr  = vq[i].a1;
      a.m1_wdata = vq[i].d1;
      @(posedge clk);
      #1;
      chk("vector", i, got_a(),
          mk_obs(vq[i].e_rd, vq[i].e_wr, vq[i].e_busy, vq[i].e_ack0, vq[i].e_ack1,
                 vq[i].e_addr, vq[i].e_wdata, vq[i].e_rd0, vq[i].e_rd1));
    end

    // Random traffic on instance a, checked every cycle by the model.
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (a.m0_ack) pend0 = 1'b0;
      if (a.m1_ack) pend1 = 1'b0;
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0      = 1'b1;
        a.m0_we    = 1'($urandom_range(0, 1));
        a.m0_addr  = 32'($urandom_range(0, 255));
        a.m0_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        a.m0_addr  = 32'($urandom_range(0, 255));
        a.m0_wdata = $urandom;
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1      = 1'b1;
        a.m1_we    = 1'($urandom_range(0, 1));
        a.m1_addr  = 32'($urandom_range(0, 255));
        a.m1_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        a.m1_addr  = 32'($urandom_range(0, 255));
        a.m1_wdata = $urandom;
      end
      a.m0_req = pend0 && ($urandom_range(0, 9) != 0);
      a.m1_req = pend1 && ($urandom_range(0, 9) != 0);
      rst      = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    a.m0_req = 1'b0;
    a.m1_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // WAIT_CYCLES=3 read on b; req drops and addr changes mid-access.
    exp_b[0] = mk_obs(1, 0, 1, 0, 0, 32'd20, 32'd0, 32'd0, 32'd0);
    exp_b[1] = exp_b[0];
    exp_b[2] = exp_b[0];
    exp_b[3] = mk_obs(0, 0, 1, 1, 0, 32'd0, 32'd0, 32'd1337, 32'd0);
    exp_b[4] = '0;
    exp_b[5] = '0;
    rd_cnt   = 0;
    ack_cnt  = 0;
    b.m0_req  = 1'b1;
    b.m0_we   = 1'b0;
    b.m0_addr = 32'd20;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("wait3", c, got_b(), exp_b[c]);
      if (b.ctrl_mem_read) rd_cnt++;
      if (b.m0_ack) ack_cnt++;
      b.m0_req  = 1'b0;
      b.m0_addr = 32'd44;
    end
    n_checks++;
    if (rd_cnt != int'(WB) || ack_cnt != 1) begin
      n_err++;
      $display("FAIL wait3_totals: got read_cycles=%0d acks=%0d required read_cycles=%0d acks=1",
               rd_cnt, ack_cnt, WB);
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
